// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared data-memory port.
// All state advances only on Tick-qualified rising edges.
module mem_port_arbiter #(
  parameter int NrOfBits     = 32,
  parameter int NrOfAddrBits = 8,
  parameter int ReadLatency  = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Tick,
  input  logic                    Req0,
  input  logic                    Req1,
  input  logic                    We0,
  input  logic                    We1,
  input  logic [NrOfAddrBits-1:0] Addr0,
  input  logic [NrOfAddrBits-1:0] Addr1,
  input  logic [NrOfBits-1:0]     WData0,
  input  logic [NrOfBits-1:0]     WData1,
  output logic                    Gnt0,
  output logic                    Gnt1,
  output logic                    Ack0,
  output logic                    Ack1,
  output logic [NrOfBits-1:0]     RData,
  output logic                    MemCs,
  output logic                    MemWe,
  output logic [NrOfAddrBits-1:0] MemAddr,
  output logic [NrOfBits-1:0]     MemWData,
  input  logic [NrOfBits-1:0]     MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [2:0] LatCnt = 3'(ReadLatency);

  state_e                  state_q, state_d;
  logic                    id_q, id_d;
  logic                    last_q, last_d;
  logic                    we_q, we_d;
  logic [NrOfAddrBits-1:0] addr_q, addr_d;
  logic [NrOfBits-1:0]     wdata_q, wdata_d;
  logic [NrOfBits-1:0]     rdata_q, rdata_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              cnt_inc;
  logic                    win1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // On a tie the requester that did not win last time gets the port.
  assign win1    = Req1 & (~Req0 | ~last_q);
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (Tick) begin
      unique case (state_q)
        IDLE: begin
          if (Req0 | Req1) begin
            id_d    = win1;
            last_d  = win1;
            we_d    = win1 ? We1 : We0;
            addr_d  = win1 ? Addr1 : Addr0;
            wdata_d = win1 ? WData1 : WData0;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_d = ACK;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LatCnt) begin
              rdata_d = MemRData;
              state_d = ACK;
            end
          end
        end
        ACK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    MemCs    = (state_q != ACCESS);
    MemWe    = (state_q == ACCESS) & we_q;
    MemAddr  = (state_q == ACCESS) ? addr_q : '0;
    MemWData = (state_q == ACCESS) ? wdata_q : '0;
    Gnt0     = (state_q != IDLE) & ~id_q;
    Gnt1     = (state_q != IDLE) & id_q;
    Ack0     = (state_q == ACK) & Tick & ~id_q;
    Ack1     = (state_q == ACK) & Tick & id_q;
    RData    = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int NB = 32;
  localparam int NA = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst, tick;
  logic req0, req1, we0, we1;
  logic [NA-1:0] a0, a1;
  logic [NB-1:0] d0, d1;
  logic gnt0, gnt1, ack0, ack1;
  logic [NB-1:0] rdata;
  logic mem_cs, mem_we;
  logic [NA-1:0] mem_addr;
  logic [NB-1:0] mem_wdata, mem_rdata;

  logic [NB-1:0] mem [256];
  logic [NB-1:0] ref_mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NrOfBits(NB), .NrOfAddrBits(NA), .ReadLatency(RL)
  ) dut (
    .Clock(clk), .Reset(rst), .Tick(tick),
    .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
    .Addr0(a0), .Addr1(a1), .WData0(d0), .WData1(d1),
    .Gnt0(gnt0), .Gnt1(gnt1), .Ack0(ack0), .Ack1(ack1),
    .RData(rdata), .MemCs(mem_cs), .MemWe(mem_we),
    .MemAddr(mem_addr), .MemWData(mem_wdata),
    .MemRData(mem_rdata)
  );

  function automatic logic [NB-1:0] init_val(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory behind the port: commits on a Tick edge while selected.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (tick && !mem_cs && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    tick = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    ref_init();
  endtask

  task automatic test_reset();
    idle_inputs();
    req0 = 1;
    rst = 1;
    step();
    step();
    ref_init();
    checks++;
    if (mem_cs !== 1'b1) begin
      errors++; $display("FAIL reset_cs got=%b exp=1", mem_cs);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_we got=%b exp=0", mem_we);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_addr got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    checks++;
    if ({gnt0, gnt1, ack0, ack1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_gnt_ack got=%b exp=0000",
               {gnt0, gnt1, ack0, ack1});
    end
    rst = 0;
    req0 = 0;
    step();
  endtask

  task automatic test_write();
    int we_cyc = 0;
    int ack_cyc = -1;
    int ack_n = 0;
    bit g1 = 0;
    bit bus_ok = 1;
    req0 = 1; we0 = 1; a0 = 8'h10; d0 = 32'hDEADBEEF; tick = 1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (!mem_cs && mem_we) begin
        we_cyc++;
        if (mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) bus_ok = 0;
      end
      if (gnt1) g1 = 1;
      if (ack0) begin
        ack_n++;
        if (ack_cyc < 0) ack_cyc = c;
        req0 = 0;
      end
    end
    ref_mem[8'h10] = 32'hDEADBEEF;
    checks++;
    if (we_cyc != 1) begin
      errors++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cyc);
    end
    checks++;
    if (!bus_ok) begin
      errors++; $display("FAIL wr_bus got=bad exp=addr10/DEADBEEF");
    end
    checks++;
    if (ack_cyc != 2 || ack_n != 1) begin
      errors++;
      $display("FAIL wr_ack got=cyc%0d/n%0d exp=cyc2/n1", ack_cyc, ack_n);
    end
    checks++;
    if (g1) begin
      errors++; $display("FAIL wr_gnt1 got=1 exp=0");
    end
  endtask

  task automatic test_read();
    int ack_cyc = -1;
    bit we_seen = 0;
    logic [NB-1:0] rd = '0;
    idle_inputs();
    req1 = 1; we1 = 0; a1 = 8'h10;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (mem_we) we_seen = 1;
      if (ack1 && ack_cyc < 0) begin
        ack_cyc = c;
        rd = rdata;
        req1 = 0;
      end
    end
    checks++;
    if (ack_cyc != RL + 1) begin
      errors++; $display("FAIL rd_ack_cycle got=%0d exp=%0d", ack_cyc, RL + 1);
    end
    checks++;
    if (rd !== ref_mem[8'h10]) begin
      errors++; $display("FAIL rd_data got=%h exp=%h", rd, ref_mem[8'h10]);
    end
    checks++;
    if (we_seen) begin
      errors++; $display("FAIL rd_we got=1 exp=0");
    end
  endtask

  task automatic test_round_robin();
    int order [4];
    int n = 0;
    int wide = 0;
    bit prev = 0;
    int exp_id;
    int last = 1;
    do_reset();
    req0 = 1; we0 = 1; a0 = 8'h20; d0 = $urandom;
    req1 = 1; we1 = 1; a1 = 8'h21; d1 = $urandom;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (ack0 || ack1) begin
        if (prev || (ack0 && ack1)) wide++;
        order[n] = ack1 ? 1 : 0;
        n++;
        if (n == 4) begin
          req0 = 0; req1 = 0;
        end
      end
      prev = ack0 | ack1;
    end
    ref_mem[8'h20] = d0;
    ref_mem[8'h21] = d1;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count got=%0d exp=4", n);
    end
    for (int k = 0; k < n; k++) begin
      exp_id = (last == 1) ? 0 : 1;
      last = exp_id;
      checks++;
      if (order[k] != exp_id) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k], exp_id);
      end
    end
    checks++;
    if (wide != 0) begin
      errors++; $display("FAIL rr_ack_width got=%0d exp=0", wide);
    end
    step();
  endtask

  task automatic test_tick_toggle();
    int ack_cyc = -1;
    int ack_n = 0;
    bit cs_ok = 1;
    logic [NB-1:0] rd = '0;
    idle_inputs();
    req0 = 1; we0 = 0; a0 = 8'h20;
    for (int c = 1; c <= 10; c++) begin
      step();
      tick = (c % 2 == 0);
      #1;
      if (c <= 2 * RL && mem_cs !== 1'b0) cs_ok = 0;
      if (ack0) begin
        ack_n++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          rd = rdata;
        end
        req0 = 0;
      end
    end
    tick = 1;
    checks++;
    if (ack_cyc != 2 * (RL + 1)) begin
      errors++;
      $display("FAIL tick_ack_cycle got=%0d exp=%0d", ack_cyc, 2 * (RL + 1));
    end
    checks++;
    if (ack_n != 1) begin
      errors++; $display("FAIL tick_ack_width got=%0d exp=1", ack_n);
    end
    checks++;
    if (!cs_ok) begin
      errors++; $display("FAIL tick_cs_hold got=released exp=selected");
    end
    checks++;
    if (rd !== ref_mem[8'h20]) begin
      errors++; $display("FAIL tick_rdata got=%h exp=%h", rd, ref_mem[8'h20]);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int ack_cyc = -1;
    do_reset();
    req0 = 1; we0 = 0; a0 = 8'h21;
    step();
    step();
    checks++;
    if (ack0 !== 1'b0 || mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre got=ack%b/cs%b exp=ack0/cs0", ack0, mem_cs);
    end
    rst = 1;
    req0 = 0;
    step();
    ref_init();
    rst = 0;
    checks++;
    if (mem_cs !== 1'b1 || mem_we !== 1'b0 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_post got=cs%b/we%b/ack%b exp=cs1/we0/ack0",
               mem_cs, mem_we, ack0);
    end
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL abort_rdata got=%h exp=0", rdata);
    end
    req0 = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ack0 && ack_cyc < 0) begin
        ack_cyc = c;
        req0 = 0;
        checks++;
        if (rdata !== ref_mem[8'h21]) begin
          errors++;
          $display("FAIL abort_reissue_data got=%h exp=%h",
                   rdata, ref_mem[8'h21]);
        end
      end
    end
    checks++;
    if (ack_cyc != RL + 1) begin
      errors++;
      $display("FAIL abort_reissue_ack got=%0d exp=%0d", ack_cyc, RL + 1);
    end
  endtask

  // Transaction model: pick order by round-robin, count Tick edges
  // per access, and keep a shadow of memory and of the read register.
  task automatic test_random();
    int mlast = 1;
    logic [NB-1:0] mrdata = '0;
    int q_id [$];
    int ticks;
    int cyc;
    int mask;
    int id;
    int exp_ticks;
    bit rw [2];
    logic [NA-1:0] ra [2];
    logic [NB-1:0] rd [2];
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mask = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        rw[r] = $urandom_range(0, 1) == 1;
        ra[r] = NA'($urandom_range(0, 15) + 8'h40);
        rd[r] = $urandom;
      end
      q_id.delete();
      if (mask == 3) begin
        q_id.push_back(mlast == 1 ? 0 : 1);
        q_id.push_back(mlast == 1 ? 1 : 0);
      end else begin
        q_id.push_back(mask == 2 ? 1 : 0);
      end
      mlast = q_id[q_id.size() - 1];
      req0 = mask[0]; we0 = rw[0]; a0 = ra[0]; d0 = rd[0];
      req1 = mask[1]; we1 = rw[1]; a1 = ra[1]; d1 = rd[1];
      ticks = 0;
      cyc = 0;
      while (q_id.size() > 0 && cyc < 300) begin
        tick = $urandom_range(0, 3) != 0;
        #1;
        cyc++;
        if (tick) ticks++;
        if (ack0 || ack1) begin
          id = q_id.pop_front();
          exp_ticks = rw[id] ? 3 : RL + 2;
          if (!rw[id]) mrdata = ref_mem[ra[id]];
          else ref_mem[ra[id]] = rd[id];
          checks++;
          if ({ack1, ack0} !== (id == 1 ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rnd_ack_id it=%0d got=%b%b exp_id=%0d",
                     it, ack1, ack0, id);
          end
          checks++;
          if ({gnt1, gnt0} !== (id == 1 ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rnd_gnt it=%0d got=%b%b exp_id=%0d",
                     it, gnt1, gnt0, id);
          end
          checks++;
          if (ticks != exp_ticks) begin
            errors++;
            $display("FAIL rnd_ticks it=%0d got=%0d exp=%0d",
                     it, ticks, exp_ticks);
          end
          checks++;
          if (rdata !== mrdata) begin
            errors++;
            $display("FAIL rnd_rdata it=%0d got=%h exp=%h",
                     it, rdata, mrdata);
          end
          if (ack0) req0 = 0;
          if (ack1) req1 = 0;
          ticks = 0;
        end
        @(posedge clk);
        #1;
      end
      checks++;
      if (q_id.size() != 0) begin
        errors++;
        $display("FAIL rnd_timeout it=%0d got=%0d pending exp=0",
                 it, q_id.size());
        req0 = 0; req1 = 0;
        do_reset();
        mlast = 1;
        mrdata = '0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_tick_toggle();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
